iob_cache_front_arbiter: RTL and testbench

- Shares one cache front-end port between N_MASTERS requesters using round-robin arbitration, for example an instruction port and a data port.
- The block sits between the requesters and the cache front-end input (req/addr/wdata/wstrb → ack/rdata).
- It issues one transaction at a time as a one-cycle req pulse with registered, stable payload.
- It routes the cache ack back to the granted requester only.

---
 rtl/iob_cache_front_arbiter.sv | 159 +++++++++++++++
 tb/tb_iob_cache_front_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_front_arbiter.sv
// ---------------------------------------------------------------------------
// iob_cache_front_arbiter
//
// Round-robin arbiter that shares one cache front-end port between
// N_MASTERS requesters (for example an instruction port and a data port).
// One transaction is in flight at a time. The winning requester's payload
// is registered at grant. The cache sees a single-cycle m_req pulse, and
// its ack is routed back only to the granted requester.
//
// Ports
//   clk, reset   clock; asynchronous active-high reset
//   s_req        per-requester request, held until that requester's s_ack
//   s_addr       packed addresses, requester i in slice i (USE_CTRL+ADDR_W each)
//   s_wdata      packed write data, requester i in slice i
//   s_wstrb      packed byte strobes, all-zero means read
//   s_ack        one-hot completion pulse towards the requesters
//   s_rdata      read data shared by all requesters, valid with s_ack
//   m_req        one-cycle request pulse to the cache
//   m_addr       registered cache address; the optional MSB (controller
//                select) is passed through untouched
//   m_wdata      registered cache write data
//   m_wstrb      registered cache byte strobes
//   m_ack        cache completion pulse
//   m_rdata      cache read data
//   busy         high while a transaction is outstanding (ISSUE or WAIT)
//   grant_id     index of the current or last granted requester
// ---------------------------------------------------------------------------
module iob_cache_front_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int USE_CTRL  = 0,
    parameter int NBYTES    = DATA_W / 8,
    parameter int IDX_W     = $clog2(N_MASTERS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [N_MASTERS-1:0]                  s_req,
    input  logic [N_MASTERS*(USE_CTRL+ADDR_W)-1:0] s_addr,
    input  logic [N_MASTERS*DATA_W-1:0]           s_wdata,
    input  logic [N_MASTERS*NBYTES-1:0]           s_wstrb,
    output logic [N_MASTERS-1:0]                  s_ack,
    output logic [DATA_W-1:0]                     s_rdata,
    output logic                                  m_req,
    output logic [USE_CTRL+ADDR_W-1:0]            m_addr,
    output logic [DATA_W-1:0]                     m_wdata,
    output logic [NBYTES-1:0]                     m_wstrb,
    input  logic                                  m_ack,
    input  logic [DATA_W-1:0]                     m_rdata,
    output logic                                  busy,
    output logic [IDX_W-1:0]                      grant_id
);

    localparam int AW = USE_CTRL + ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  grant_id_reg;
    logic [IDX_W-1:0]  last_reg;
    logic [AW-1:0]     m_addr_reg;
    logic [DATA_W-1:0] m_wdata_reg;
    logic [NBYTES-1:0] m_wstrb_reg;

    logic [IDX_W-1:0]  winner;
    logic              any_req;
    logic              grant;

    // Unpack the requester slices so the winner can select them by index.
    logic [AW-1:0]     addr_slice  [N_MASTERS];
    logic [DATA_W-1:0] wdata_slice [N_MASTERS];
    logic [NBYTES-1:0] wstrb_slice [N_MASTERS];

    genvar gi;
    generate
        for (gi = 0; gi < N_MASTERS; gi++) begin : g_slice
            assign addr_slice[gi]  = s_addr[gi*AW +: AW];
            assign wdata_slice[gi] = s_wdata[gi*DATA_W +: DATA_W];
            assign wstrb_slice[gi] = s_wstrb[gi*NBYTES +: NBYTES];
            // busy gates off acks that arrive while idle, including stray
            // acks from a transaction aborted by reset.
            assign s_ack[gi] = m_ack & busy & (grant_id_reg == IDX_W'(gi));
        end
    endgenerate

    assign any_req = |s_req;
    assign grant   = (state_reg == ST_IDLE) && any_req;

    // Round-robin search: first set request starting just after the last
    // winner, wrapping modulo N_MASTERS (works for non-power-of-two counts).
    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx = (int'(last_reg) + k) % N_MASTERS;
            if (!found && s_req[idx]) begin
                found  = 1'b1;
                winner = idx[IDX_W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (any_req) state_next = ST_ISSUE;
            ST_ISSUE: state_next = m_ack ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (m_ack) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Grant bookkeeping and payload capture; payload only changes at grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id_reg <= '0;
            last_reg     <= IDX_W'(N_MASTERS - 1);
            m_addr_reg   <= '0;
            m_wdata_reg  <= '0;
            m_wstrb_reg  <= '0;
        end else if (grant) begin
            grant_id_reg <= winner;
            last_reg     <= winner;
            m_addr_reg   <= addr_slice[winner];
            m_wdata_reg  <= wdata_slice[winner];
            m_wstrb_reg  <= wstrb_slice[winner];
        end
    end

    // Output logic
    always_comb begin
        m_req = (state_reg == ST_ISSUE);
        busy  = (state_reg != ST_IDLE);
    end

    assign m_addr   = m_addr_reg;
    assign m_wdata  = m_wdata_reg;
    assign m_wstrb  = m_wstrb_reg;
    assign grant_id = grant_id_reg;
    assign s_rdata  = m_rdata;

endmodule

// File: tb/tb_iob_cache_front_arbiter.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for iob_cache_front_arbiter.
// dut  : N_MASTERS=2, USE_CTRL=1 (33-bit addresses, MSB = controller select)
// dut3 : N_MASTERS=3, USE_CTRL=0 (round-robin rotation and wrap-around)
// ---------------------------------------------------------------------------
module tb_iob_cache_front_arbiter;

    logic clk;
    logic reset;

    // two-requester instance, USE_CTRL=1
    logic [1:0]  s_req;
    logic [65:0] s_addr;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    logic [1:0]  s_ack;
    logic [31:0] s_rdata;
    logic        m_req;
    logic [32:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        busy;
    logic [0:0]  grant_id;

    // three-requester instance, USE_CTRL=0
    logic [2:0]  s_req3;
    logic [95:0] s_addr3;
    logic [95:0] s_wdata3;
    logic [11:0] s_wstrb3;
    logic [2:0]  s_ack3;
    logic [31:0] s_rdata3;
    logic        m_req3;
    logic [31:0] m_addr3;
    logic [31:0] m_wdata3;
    logic [3:0]  m_wstrb3;
    logic        m_ack3;
    logic [31:0] m_rdata3;
    logic        busy3;
    logic [1:0]  grant_id3;

    int total;
    int bad;
    int rr_exp [4];

    iob_cache_front_arbiter #(
        .N_MASTERS(2), .ADDR_W(32), .DATA_W(32), .USE_CTRL(1)
    ) dut (
        .clk(clk), .reset(reset),
        .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ack(s_ack), .s_rdata(s_rdata),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ack(m_ack), .m_rdata(m_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    iob_cache_front_arbiter #(
        .N_MASTERS(3), .ADDR_W(32), .DATA_W(32), .USE_CTRL(0)
    ) dut3 (
        .clk(clk), .reset(reset),
        .s_req(s_req3), .s_addr(s_addr3), .s_wdata(s_wdata3), .s_wstrb(s_wstrb3),
        .s_ack(s_ack3), .s_rdata(s_rdata3),
        .m_req(m_req3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_wstrb(m_wstrb3),
        .m_ack(m_ack3), .m_rdata(m_rdata3),
        .busy(busy3), .grant_id(grant_id3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, want);
        end
        $display("check %-18s observed=0x%0h expected=0x%0h", tag, got, want);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rr_exp = '{0, 1, 2, 0};
        reset = 1'b1;
        s_req = '0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
        m_ack = 1'b0; m_rdata = '0;
        s_req3 = '0; s_addr3 = '0; s_wdata3 = '0; s_wstrb3 = '0;
        m_ack3 = 1'b0; m_rdata3 = '0;

        // ---- reset values; an ack while idle is ignored ----
        tick(); tick();
        m_ack = 1'b1;
        #1;
        chk("rst_m_req", m_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_m_wstrb", m_wstrb, 0);
        chk("rst_s_ack", s_ack, 0);
        m_ack = 1'b0;
        reset = 1'b0;

        // ---- 1: single read, cache acks 3 cycles after m_req ----
        s_addr[0 +: 33] = 33'h100;
        s_req = 2'b01;
        tick();
        chk("t1_m_req", m_req, 1);
        chk("t1_m_addr", m_addr, 33'h100);
        chk("t1_busy_c1", busy, 1);
        chk("t1_grant", grant_id, 0);
        chk("t1_wstrb_read", m_wstrb, 0);
        tick();
        chk("t1_m_req_c2", m_req, 0);
        chk("t1_busy_c2", busy, 1);
        tick();
        chk("t1_m_req_c3", m_req, 0);
        chk("t1_busy_c3", busy, 1);
        chk("t1_no_early_ack", s_ack, 0);
        tick();
        chk("t1_busy_c4", busy, 1);
        m_ack = 1'b1;
        m_rdata = 32'hDEADBEEF;
        #1;
        chk("t1_s_ack", s_ack, 2'b01);
        chk("t1_s_rdata", s_rdata, 32'hDEADBEEF);
        tick();
        chk("t1_busy_c5", busy, 0);
        chk("t1_idle_ack", s_ack, 0);
        s_req = 2'b00;
        m_ack = 1'b0;
        tick();
        chk("t1_idle_m_req", m_req, 0);

        // ---- 2: contention with ack in every issue cycle ----
        reset = 1'b1;
        #1;
        reset = 1'b0;
        s_addr[0 +: 33]  = 33'h10;
        s_addr[33 +: 33] = 33'h20;
        s_req = 2'b11;
        m_ack = 1'b1;
        m_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_m_req", m_req, 1);
            chk("t2_m_addr", m_addr, (i % 2 == 0) ? 64'h10 : 64'h20);
            chk("t2_s_ack", s_ack, (i % 2 == 0) ? 64'h1 : 64'h2);
            tick();
            chk("t2_bubble", m_req, 0);
            chk("t2_bubble_busy", busy, 0);
        end
        s_req = 2'b00;
        m_ack = 1'b0;

        // ---- 3: write from requester 1, ack in the issue cycle ----
        s_addr[33 +: 33]  = 33'h40;
        s_wdata[32 +: 32] = 32'hA5A5A5A5;
        s_wstrb[4 +: 4]   = 4'b0011;
        s_req = 2'b10;
        tick();
        chk("t3_grant", grant_id, 1);
        chk("t3_m_req", m_req, 1);
        chk("t3_m_addr", m_addr, 33'h40);
        chk("t3_m_wdata", m_wdata, 32'hA5A5A5A5);
        chk("t3_m_wstrb", m_wstrb, 4'b0011);
        m_ack = 1'b1;
        #1;
        chk("t3_s_ack", s_ack, 2'b10);
        tick();
        chk("t3_no_wait", busy, 0);
        chk("t3_m_req_low", m_req, 0);
        s_req = 2'b00;
        m_ack = 1'b0;

        // ---- 4: payload stays stable while waiting ----
        s_addr[0 +: 33] = 33'h100;
        s_req = 2'b01;
        tick();
        chk("t4_grant", grant_id, 0);
        chk("t4_m_addr", m_addr, 33'h100);
        s_addr[0 +: 33] = 33'hFFF;
        tick();
        chk("t4_wait_addr", m_addr, 33'h100);
        chk("t4_wait_busy", busy, 1);
        chk("t4_wait_m_req", m_req, 0);
        tick();
        chk("t4_wait_addr2", m_addr, 33'h100);
        m_ack = 1'b1;
        #1;
        chk("t4_s_ack", s_ack, 2'b01);
        tick();
        chk("t4_idle", busy, 0);
        s_req = 2'b00;
        m_ack = 1'b0;

        // ---- 5: asynchronous reset during WAIT, stray ack afterwards ----
        s_addr[0 +: 33] = 33'h300;
        s_req = 2'b01;
        tick();
        chk("t5_grant", grant_id, 0);
        tick();
        chk("t5_in_wait", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_m_req", m_req, 0);
        chk("t5_rst_m_addr", m_addr, 0);
        chk("t5_rst_grant", grant_id, 0);
        s_req = 2'b00;
        #2;
        reset = 1'b0;
        m_ack = 1'b1;
        #1;
        chk("t5_stray_ack", s_ack, 0);
        tick();
        chk("t5_stray_busy", busy, 0);
        chk("t5_stray_ack2", s_ack, 0);
        m_ack = 1'b0;
        s_addr[33 +: 33] = 33'h20;
        s_req = 2'b11;
        tick();
        chk("t5_first_grant", grant_id, 0);
        chk("t5_first_addr", m_addr, 33'h300);
        m_ack = 1'b1;
        #1;
        chk("t5_s_ack", s_ack, 2'b01);
        tick();
        s_req = 2'b00;
        m_ack = 1'b0;

        // ---- 6: controller-select MSB passes through ----
        s_addr[0 +: 33] = {1'b1, 32'h0000_0200};
        s_req = 2'b01;
        tick();
        chk("t6_m_addr", m_addr, 33'h1_0000_0200);
        chk("t6_msb", m_addr[32], 1);
        m_ack = 1'b1;
        m_rdata = 32'h12345678;
        #1;
        chk("t6_s_ack", s_ack, 2'b01);
        chk("t6_s_rdata", s_rdata, 32'h12345678);
        tick();
        s_req = 2'b00;
        m_ack = 1'b0;
        chk("t6_idle", busy, 0);

        // ---- 7: three requesters, rotation and wrap-around ----
        for (int i = 0; i < 3; i++) s_addr3[i*32 +: 32] = 32'h1000 + 32'(i);
        s_req3 = 3'b111;
        m_ack3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t7_rr_grant", grant_id3, rr_exp[i]);
            chk("t7_rr_addr", m_addr3, 64'h1000 + 64'(rr_exp[i]));
            chk("t7_rr_ack", s_ack3, 64'h1 << rr_exp[i]);
            tick();
            chk("t7_rr_bubble", m_req3, 0);
        end
        s_req3 = 3'b101;
        tick();
        chk("t7_wrap_grant2", grant_id3, 2);
        chk("t7_wrap_ack2", s_ack3, 3'b100);
        tick();
        s_req3 = 3'b011;
        tick();
        chk("t7_wrap_grant0", grant_id3, 0);
        chk("t7_wrap_ack0", s_ack3, 3'b001);
        tick();
        s_req3 = 3'b000;
        m_ack3 = 1'b0;
        tick();
        chk("t7_idle", busy3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
